param_mem: RTL

//  Parametrised synchronous RAM; successor to the fixed 16x8 wr/rd memory.

---
 rtl/param_mem_pkg.sv | 14 +
 rtl/param_mem_clr_ctrl.sv | 33 +++
 rtl/param_mem.sv | 61 ++++++
 3 files changed

// File: rtl/param_mem_pkg.sv
// param_mem_pkg: shared types and byte-merge helper for param_mem
package param_mem_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam int MAX_BW = 32;
  localparam int MAX_DW = 8 * MAX_BW;
  // Operates on the widest supported word; callers zero-extend and truncate.
  function automatic logic [MAX_DW-1:0] merge_be(input logic [MAX_DW-1:0] old_w,
                                                 input logic [MAX_DW-1:0] new_w,
                                                 input logic [MAX_BW-1:0] be);
    merge_be = old_w;
    for (int i = 0; i < MAX_BW; i++)
      if (be[i]) merge_be[8*i +: 8] = new_w[8*i +: 8];
  endfunction
endpackage

// File: rtl/param_mem_clr_ctrl.sv
// param_mem_clr_ctrl: post-reset clear sweep FSM and ready flag
module param_mem_clr_ctrl
  import param_mem_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLEAR_ON_RST = 1,
  parameter int AW           = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  state_t state, state_n;
  logic [AW-1:0] clr_ptr;
  always_comb begin
    state_n = (state == ST_CLEAR && clr_ptr == AW'(DEPTH - 1)) ? ST_READY : state;
    clr_we = state == ST_CLEAR;
    clr_addr = clr_ptr;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      clr_ptr <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      clr_ptr <= (state == ST_CLEAR) ? clr_ptr + AW'(1) : clr_ptr;
      ready <= state_n == ST_READY;
    end
  end
endmodule

// File: rtl/param_mem.sv
// param_mem: parametrised sync RAM with byte enables, clear sweep and range check
module param_mem
  import param_mem_pkg::*;
#(
  parameter int            DW           = 8,
  parameter int            DEPTH        = 16,
  parameter int            CLEAR_ON_RST = 1,
  parameter logic [DW-1:0] INIT_VAL     = '0,
  parameter int            WRITE_FIRST  = 1,
  localparam int           AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int           BW           = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic          rd,
  input  logic [BW-1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] Datain,
  output logic [DW-1:0] Dataout,
  output logic          rd_valid,
  output logic          ready,
  output logic          addr_err
);
  logic [DW-1:0] mem [DEPTH];
  logic clr_we, in_rng, acc, we;
  logic [AW-1:0] clr_addr, raddr, waddr;
  logic [DW-1:0] cur, merged, wdata;
  param_mem_clr_ctrl #(.DEPTH(DEPTH), .CLEAR_ON_RST(CLEAR_ON_RST), .AW(AW)) u_clr (
    .clk(clk),
    .rst_n(rst_n),
    .ready(ready),
    .clr_we(clr_we),
    .clr_addr(clr_addr)
  );
  // Out-of-range addresses are steered to word 0 so the array is never indexed past DEPTH.
  always_comb begin
    in_rng = {1'b0, addr} < (AW + 1)'(DEPTH);
    acc = ready & rst_n;
    raddr = in_rng ? addr : '0;
    cur = mem[raddr];
    merged = DW'(merge_be(MAX_DW'(cur), MAX_DW'(Datain), MAX_BW'(be)));
    we = clr_we | (acc & wr & in_rng);
    waddr = clr_we ? clr_addr : raddr;
    wdata = clr_we ? INIT_VAL : merged;
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Dataout <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= acc & rd;
      addr_err <= acc & (rd | wr) & ~in_rng;
      if (acc & rd) Dataout <= !in_rng ? '0 : (WRITE_FIRST != 0 && wr) ? merged : cur;
    end
  end
endmodule
